nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 28 ++
 rtl/nibble_serial_adder_ctrl_nibble_adder.sv | 33 +++
 rtl/nibble_serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl_pkg
// Description : Shared constants, state encoding and helpers for the
//               nibble-serial adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_ctrl_pkg;

    // Width of the shared adder slice
    localparam int NIBBLE_W = 4;

    // Sequencer states with fixed encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed overflow of an addition, given the sign bits of the two
    // addends (B already inverted for subtract) and of the sum
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_adder
// Description : Combinational 4-bit ripple-carry adder slice shared by all
//               nibbles of the serial sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_adder
    import nibble_serial_adder_ctrl_pkg::*;
(
    output logic [NIBBLE_W-1:0] o_w_s,
    output logic                o_w_cout,
    input  logic [NIBBLE_W-1:0] i_w_a,
    input  logic [NIBBLE_W-1:0] i_w_b,
    input  logic                i_w_cin
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = i_w_cin;

    // One full adder per bit; carry ripples LSB to MSB
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign o_w_s[i]   = i_w_a[i] ^ i_w_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_w_a[i] & i_w_b[i]) |
                            (i_w_a[i] & w_c[i])   |
                            (i_w_b[i] & w_c[i]);
    end

    assign o_w_cout = w_c[NIBBLE_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Adds or subtracts two NIBBLES-wide operands by time-sharing a
//               single 4-bit adder, one nibble per clock starting at the LSB.
//               Results are published only when the last nibble completes.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       i_w_clk,
    input  logic                       i_w_rst_n,
    input  logic                       i_w_start,
    input  logic [NIBBLES*NIBBLE_W-1:0] i_w_a,
    input  logic [NIBBLES*NIBBLE_W-1:0] i_w_b,
    input  logic                       i_w_cin,
    input  logic                       i_w_sub,
    output logic                       o_w_busy,
    output logic                       o_w_done,
    output logic [NIBBLES*NIBBLE_W-1:0] o_w_s,
    output logic                       o_w_cout,
    output logic                       o_w_ovf
);

    localparam int W     = NIBBLES * NIBBLE_W;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;        // B, pre-inverted for subtract
    logic [W-1:0]       r_partial;
    logic               r_carry;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_s_nib;
    logic                w_cout;
    logic [W-1:0]        w_sum_full;

    // Current nibble of each operand feeds the shared adder
    assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

    nibble_adder u_nibble_adder (
        .o_w_s    (w_s_nib),
        .o_w_cout (w_cout),
        .i_w_a    (w_a_nib),
        .i_w_b    (w_b_nib),
        .i_w_cin  (r_carry)
    );

    // Partial result with this cycle's nibble merged in, so the final
    // nibble is included when the result is published
    always_comb begin
        w_sum_full = r_partial;
        w_sum_full[r_idx*NIBBLE_W +: NIBBLE_W] = w_s_nib;
    end

    // Sequencer: accept, step through nibbles, publish, pulse done
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_partial <= '0;
            r_carry   <= 1'b0;
            o_w_busy  <= 1'b0;
            o_w_done  <= 1'b0;
            o_w_s     <= '0;
            o_w_cout  <= 1'b0;
            o_w_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    o_w_done <= 1'b0;
                    if (i_w_start) begin
                        r_a      <= i_w_a;
                        // Subtract is A + ~B + ~borrow_in
                        r_b      <= i_w_sub ? ~i_w_b : i_w_b;
                        r_carry  <= i_w_cin ^ i_w_sub;
                        r_idx    <= '0;
                        o_w_busy <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_partial <= w_sum_full;
                    r_carry   <= w_cout;
                    if (r_idx == C_LAST_IDX) begin
                        r_idx    <= '0;
                        o_w_busy <= 1'b0;
                        o_w_done <= 1'b1;
                        o_w_s    <= w_sum_full;
                        o_w_cout <= w_cout;
                        o_w_ovf  <= add_ovf(r_a[W-1], r_b[W-1], w_sum_full[W-1]);
                        r_state  <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    o_w_done <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    o_w_busy <= 1'b0;
                    o_w_done <= 1'b0;
                    r_idx    <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder_ctrl
// Description : Self-checking bench: directed vector table, ignored-start and
//               mid-run reset sequences, and randomized operations compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         sub   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] held_s    = '0;
    logic         held_cout = 1'b0;
    logic         held_ovf  = 1'b0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_s;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .i_w_clk   (clk),
        .i_w_rst_n (rst_n),
        .i_w_start (start),
        .i_w_a     (a),
        .i_w_b     (b),
        .i_w_cin   (cin),
        .i_w_sub   (sub),
        .o_w_busy  (busy),
        .o_w_done  (done),
        .o_w_s     (s),
        .o_w_cout  (cout),
        .o_w_ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the whole operands
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [W-1:0] ms, output logic mco,
                                  output logic mov);
        logic [W:0] t;
        if (!msub) begin
            t   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
            ms  = t[W-1:0];
            mco = t[W];
            mov = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
        end else begin
            t   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mcin};
            ms  = t[W-1:0];
            mco = ~t[W];   // 1 = no borrow
            mov = (ma[W-1] != mb[W-1]) && (ms[W-1] != ma[W-1]);
        end
    endfunction

    // Run one operation; optionally poke start at E2; check timing and hold
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts, input bit poke,
                          input bit now,
                          output logic [W-1:0] rs, output logic rco, output logic rov);
        int cyc;
        int busy_cnt;
        int done_cnt;
        if (!now) @(negedge clk);
        a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            check("hold_s_in_run", s, held_s);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            if (poke && cyc == 1) begin
                start = 1'b1;
                a = 16'hAAAA;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("busy_cycles", busy_cnt, NIBBLES);
        check("busy_at_done", busy, 0);
        rs = s; rco = cout; rov = ovf;
        held_s = s; held_cout = cout; held_ovf = ovf;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) done_cnt += 100;
        end
        check("single_done_no_restart", done_cnt, 0);
        check("result_held", s, held_s);
    endtask

    initial begin
        vec_t         vecs[6];
        logic [W-1:0] rs;
        logic         rco, rov;
        logic [W-1:0] ms;
        logic         mco, mov;
        int           done_cnt;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};

        // Reset and idle
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s", s, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_s", s, 16'h0000);
            check("idle_cout", cout, 0);
            check("idle_ovf", ovf, 0);
        end

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0, 1'b0, rs, rco, rov);
            check($sformatf("vec%0d_s", i), rs, vecs[i].exp_s);
            check($sformatf("vec%0d_cout", i), rco, vecs[i].exp_cout);
            check($sformatf("vec%0d_ovf", i), rov, vecs[i].exp_ovf);
        end

        // Start pulsed at E2 during RUN is ignored
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 1'b0, rs, rco, rov);
        check("poke_s", rs, 16'h5555);
        check("poke_cout", rco, 0);

        // Reset between E2 and E3 aborts the operation
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_s", s, 16'h0000);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        check("abort_done", done, 0);
        done_cnt = 0;
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        held_s = '0; held_cout = 1'b0; held_ovf = 1'b0;
        rst_n = 1'b1;
        // Start high on the first edge after release
        run_op(16'h0F0F, 16'h0101, 1'b1, 1'b0, 1'b0, 1'b1, rs, rco, rov);
        check("abort_no_done", done_cnt, 0);
        check("after_abort_s", rs, 16'h1011);
        check("after_abort_cout", rco, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc, rsb;
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rsb = 1'($urandom);
            if (i % 7 == 0) rb = ~ra;
            model(ra, rb, rc, rsb, ms, mco, mov);
            run_op(ra, rb, rc, rsb, 1'b0, 1'b0, rs, rco, rov);
            check($sformatf("rnd%0d_s", i), rs, ms);
            check($sformatf("rnd%0d_cout", i), rco, mco);
            check($sformatf("rnd%0d_ovf", i), rov, mov);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
